wb_stage: RTL and testbench

//   Write-back stage: merges ALU results and LSU load responses into the single

---
 rtl/wb_stage.sv | 156 +++++++++++++++
 tb/tb_wb_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates ALU results and LSU load responses onto the
// single regfile write port, buffering ALU results while a load owns it.
module wb_stage #(
   parameter int XLEN           = 32,
   parameter int REG_IDX_WIDTH  = 5,
   parameter int ALU_FIFO_DEPTH = 2,
   parameter int STARVE_MAX     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_vld_i,
   output logic                     alu_rdy_o,
   input  logic [REG_IDX_WIDTH-1:0] alu_rd_idx_i,
   input  logic [XLEN-1:0]          alu_wdata_i,
   input  logic                     lsu_vld_i,
   output logic                     lsu_rdy_o,
   input  logic [REG_IDX_WIDTH-1:0] lsu_rd_idx_i,
   input  logic [2:0]               lsu_funct3_i,
   input  logic [1:0]               lsu_addr_lo_i,
   input  logic [XLEN-1:0]          lsu_rdata_i,
   output logic                     rd_en_o,
   output logic [REG_IDX_WIDTH-1:0] rd_idx_o,
   output logic [XLEN-1:0]          rd_wdata_o
);

   localparam int PW = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
   localparam int CW = $clog2(ALU_FIFO_DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [REG_IDX_WIDTH-1:0] r_fifo_idx  [ALU_FIFO_DEPTH];
   logic [XLEN-1:0]          r_fifo_data [ALU_FIFO_DEPTH];
   logic [PW-1:0]            r_wr_ptr;
   logic [PW-1:0]            r_rd_ptr;
   logic [CW-1:0]            r_cnt;
   logic [SW-1:0]            r_starve;
   logic                     r_rd_en;
   logic [REG_IDX_WIDTH-1:0] r_rd_idx;
   logic [XLEN-1:0]          r_rd_wdata;

   logic                     w_empty;
   logic                     w_full;
   logic                     w_alu_acc;
   logic                     w_lsu_acc;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_wr_vld;
   logic [REG_IDX_WIDTH-1:0] w_wr_idx;
   logic [XLEN-1:0]          w_wr_data;
   logic [7:0]               w_byte;
   logic [15:0]              w_half;
   logic [XLEN-1:0]          w_load;

   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == CW'(ALU_FIFO_DEPTH));
   assign alu_rdy_o = !w_full;
   assign lsu_rdy_o = (r_starve != SW'(STARVE_MAX));
   assign w_alu_acc = alu_vld_i & alu_rdy_o;
   assign w_lsu_acc = lsu_vld_i & lsu_rdy_o;

   // Misaligned halfword (addr_lo=11) falls onto the upper half.
   assign w_byte = lsu_rdata_i[{lsu_addr_lo_i, 3'b000} +: 8];
   assign w_half = lsu_rdata_i[{lsu_addr_lo_i[1], 4'b0000} +: 16];

   always_comb begin
      w_load = lsu_rdata_i;
      case (lsu_funct3_i)
         3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
         3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
         3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
         3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
         default: w_load = lsu_rdata_i;
      endcase
   end

   always_comb begin
      w_wr_vld  = 1'b0;
      w_wr_idx  = '0;
      w_wr_data = '0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      priority case (1'b1)
         w_lsu_acc: begin
            w_wr_vld  = 1'b1;
            w_wr_idx  = lsu_rd_idx_i;
            w_wr_data = w_load;
            w_push    = w_alu_acc;
         end
         !w_empty: begin
            w_wr_vld  = 1'b1;
            w_wr_idx  = r_fifo_idx[r_rd_ptr];
            w_wr_data = r_fifo_data[r_rd_ptr];
            w_pop     = 1'b1;
            w_push    = w_alu_acc;
         end
         alu_vld_i: begin
            w_wr_vld  = 1'b1;
            w_wr_idx  = alu_rd_idx_i;
            w_wr_data = alu_wdata_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_idx[r_wr_ptr]  <= alu_rd_idx_i;
         r_fifo_data[r_wr_ptr] <= alu_wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Counts LSU wins that left queued ALU results waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (w_lsu_acc && !w_empty) begin
         r_starve <= r_starve + 1'b1;
      end else if (w_pop || w_empty) begin
         r_starve <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_en    <= 1'b0;
         r_rd_idx   <= '0;
         r_rd_wdata <= '0;
      end else begin
         r_rd_en <= w_wr_vld && (w_wr_idx != '0);
         if (w_wr_vld) begin
            r_rd_idx   <= w_wr_idx;
            r_rd_wdata <= w_wr_data;
         end
      end
   end

   assign rd_en_o    = r_rd_en;
   assign rd_idx_o   = r_rd_idx;
   assign rd_wdata_o = r_rd_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios then random traffic against a
// queue-based model of the write-port arbitration rules.
module tb_wb_stage;

   localparam int DEPTH = 2;
   localparam int SMAX  = 4;

   logic        clk;
   logic        rst_n;
   logic        alu_vld_i;
   logic        alu_rdy_o;
   logic [4:0]  alu_rd_idx_i;
   logic [31:0] alu_wdata_i;
   logic        lsu_vld_i;
   logic        lsu_rdy_o;
   logic [4:0]  lsu_rd_idx_i;
   logic [2:0]  lsu_funct3_i;
   logic [1:0]  lsu_addr_lo_i;
   logic [31:0] lsu_rdata_i;
   logic        rd_en_o;
   logic [4:0]  rd_idx_o;
   logic [31:0] rd_wdata_o;

   wb_stage #(
      .XLEN(32), .REG_IDX_WIDTH(5),
      .ALU_FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_vld_i(alu_vld_i), .alu_rdy_o(alu_rdy_o),
      .alu_rd_idx_i(alu_rd_idx_i), .alu_wdata_i(alu_wdata_i),
      .lsu_vld_i(lsu_vld_i), .lsu_rdy_o(lsu_rdy_o),
      .lsu_rd_idx_i(lsu_rd_idx_i), .lsu_funct3_i(lsu_funct3_i),
      .lsu_addr_lo_i(lsu_addr_lo_i), .lsu_rdata_i(lsu_rdata_i),
      .rd_en_o(rd_en_o), .rd_idx_o(rd_idx_o), .rd_wdata_o(rd_wdata_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];
   int   m_starve;
   int   errors;
   int   checks;
   bit   obs_ardy;
   bit   obs_lrdy;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] load_fmt(input logic [2:0] f3,
                                            input logic [1:0] alo,
                                            input logic [31:0] rd);
      int unsigned b, h;
      b = (rd >> (8 * alo)) & 32'hFF;
      h = (rd >> (alo >= 2 ? 16 : 0)) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? b - 256 : b;
         3'b001:  return (h >= 32768) ? h - 65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return rd;
      endcase
   endfunction

   task automatic idle_in();
      alu_vld_i     = 1'b0;
      lsu_vld_i     = 1'b0;
      alu_rd_idx_i  = '0;
      alu_wdata_i   = '0;
      lsu_rd_idx_i  = '0;
      lsu_funct3_i  = '0;
      lsu_addr_lo_i = '0;
      lsu_rdata_i   = '0;
   endtask

   task automatic step(input bit av, input logic [4:0] ai,
                       input logic [31:0] ad, input bit lv,
                       input logic [4:0] li, input logic [2:0] f3,
                       input logic [1:0] alo, input logic [31:0] rd);
      ent_t e;
      bit ardy, lrdy, has;
      logic [4:0] widx;
      logic [31:0] wdat;
      int sz;
      @(negedge clk);
      alu_vld_i = av; alu_rd_idx_i = ai; alu_wdata_i = ad;
      lsu_vld_i = lv; lsu_rd_idx_i = li; lsu_funct3_i = f3;
      lsu_addr_lo_i = alo; lsu_rdata_i = rd;
      #1;
      sz = mq.size();
      ardy = (sz < DEPTH);
      lrdy = (m_starve != SMAX);
      obs_ardy = alu_rdy_o;
      obs_lrdy = lsu_rdy_o;
      check("alu_rdy", {31'b0, alu_rdy_o}, {31'b0, ardy});
      check("lsu_rdy", {31'b0, lsu_rdy_o}, {31'b0, lrdy});
      has = 1'b0; widx = '0; wdat = '0;
      if (lv && lrdy) begin
         has = 1'b1; widx = li; wdat = load_fmt(f3, alo, rd);
         if (av && ardy) mq.push_back('{ai, ad});
         m_starve = (sz != 0) ? m_starve + 1 : 0;
      end else if (sz > 0) begin
         e = mq.pop_front();
         has = 1'b1; widx = e.idx; wdat = e.data;
         if (av && ardy) mq.push_back('{ai, ad});
         m_starve = 0;
      end else if (av) begin
         has = 1'b1; widx = ai; wdat = ad;
         m_starve = 0;
      end else begin
         m_starve = 0;
      end
      @(posedge clk);
      #1;
      idle_in();
      check("rd_en", {31'b0, rd_en_o}, {31'b0, (has && widx != 0)});
      if (has && widx != 0) begin
         check("rd_idx", {27'b0, rd_idx_o}, {27'b0, widx});
         check("rd_wdata", rd_wdata_o, wdat);
      end
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      errors = 0; checks = 0; m_starve = 0;
      idle_in();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_en", {31'b0, rd_en_o}, 32'd0);
      check("rst_idx", {27'b0, rd_idx_o}, 32'd0);
      check("rst_wdata", rd_wdata_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_ardy", {31'b0, alu_rdy_o}, 32'd1);
      check("rst_lrdy", {31'b0, lsu_rdy_o}, 32'd1);

      // bypass write
      step(1, 5, 32'h1234, 0, 0, 0, 0, 0);
      check("t1_idx", {27'b0, rd_idx_o}, 32'd5);
      check("t1_wdata", rd_wdata_o, 32'h1234);

      // load formatting
      step(0, 0, 0, 1, 3, 3'b000, 2, 32'h0080_0000);
      check("t2_lb", rd_wdata_o, 32'hFFFF_FF80);
      step(0, 0, 0, 1, 3, 3'b100, 2, 32'h0080_0000);
      check("t2_lbu", rd_wdata_o, 32'h0000_0080);
      step(0, 0, 0, 1, 3, 3'b001, 2, 32'h8001_0000);
      check("t2_lh", rd_wdata_o, 32'hFFFF_8001);
      step(0, 0, 0, 1, 4, 3'b101, 3, 32'h9abc_0000);
      check("t2_lhu_mis", rd_wdata_o, 32'h0000_9abc);
      step(0, 0, 0, 1, 4, 3'b110, 1, 32'hcafe_f00d);
      check("t2_resv", rd_wdata_o, 32'hcafe_f00d);

      // simultaneous LSU and ALU
      step(1, 8, 32'h88, 1, 7, 3'b010, 0, 32'h77);
      check("t3_ardy", {31'b0, obs_ardy}, 32'd1);
      check("t3_first", {27'b0, rd_idx_o}, 32'd7);
      nop();
      check("t3_second", {27'b0, rd_idx_o}, 32'd8);

      // starvation limit
      for (int k = 0; k < 6; k++) begin
         step(1, 5'(10 + k), 32'(k + 100), 1, 5'(20 + k), 3'b010, 0,
              32'(k + 200));
         if (k == 2) check("t4_full", {31'b0, obs_ardy}, 32'd0);
         if (k == 5) check("t4_starve", {31'b0, obs_lrdy}, 32'd0);
      end
      check("t4_drain", {27'b0, rd_idx_o}, 32'd10);
      repeat (3) nop();

      // write to x0 is dropped but consumes its entry
      step(1, 0, 32'hDEAD, 1, 4, 3'b010, 0, 32'h44);
      step(1, 9, 32'h99, 1, 6, 3'b010, 0, 32'h66);
      nop();
      check("t5_x0", {31'b0, rd_en_o}, 32'd0);
      nop();
      check("t5_next", {27'b0, rd_idx_o}, 32'd9);

      // reset with entries queued
      step(1, 11, 32'hB1, 1, 12, 3'b010, 0, 32'hC1);
      step(1, 13, 32'hB2, 1, 14, 3'b010, 0, 32'hC2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_rst_en", {31'b0, rd_en_o}, 32'd0);
      mq.delete();
      m_starve = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         nop();
         check("t6_stale", {31'b0, rd_en_o}, 32'd0);
      end

      for (int n = 0; n < 400; n++) begin
         step(($urandom % 3) != 0, 5'($urandom), $urandom,
              ($urandom % 4) != 0, 5'($urandom), 3'($urandom),
              2'($urandom), $urandom);
      end
      repeat (4) nop();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
